mat_scan_arb: RTL and testbench
===============================

Name: mat_scan_arb

Overview:
- Block-granular round-robin arbiter that shares one mat_scan zigzag engine between two sample-block producers.
- Each producer supplies 8x8 blocks of 10-bit samples as 64-beat streams.
- Grants whole blocks, serialises them into mat_scan, and tracks block ownership in a tag FIFO.
- Routes each 64-beat scanned output block back to the requester that owns it.

Parameters:
- DW, 10, sample width (matches mat_scan din/dout).
- BLK, 64, beats per block (8x8).
- TAG_DEPTH, 2, maximum blocks in flight inside mat_scan (power of 2, at least 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s0_req  in  1  requester 0 has a block ready.
- s0_vld  in  1  requester 0 sample valid.
- s0_din  in  DW  requester 0 sample.
- s0_rdy  out  1  requester 0 granted; a beat transfers when s0_vld & s0_rdy.
- s1_req, s1_vld, s1_din, s1_rdy  same as above for requester 1.
- scan_vld_in  out  1  to mat_scan vld_in.
- scan_din  out  DW  to mat_scan din.
- scan_vld_out  in  1  from mat_scan vld_out.
- scan_dout  in  DW  from mat_scan dout.
- m0_vld  out  1  scanned sample valid for requester 0.
- m0_dout  out  DW  scanned sample for requester 0.
- m1_vld, m1_dout  same as above for requester 1.
- busy  out  1  state is FEED or tag FIFO is non-empty.
- err_orphan  out  1  sticky flag: scan_vld_out arrived while the tag FIFO was empty.

Behaviour:
- Reset: state IDLE, priority pointer 0, tag FIFO empty, both beat counters 0. All outputs 0: s*_rdy, scan_vld_in, scan_din, m*_vld, m*_dout, busy, err_orphan.
- mat_scan must share the same reset. A reset mid-block abandons that block and clears all tags.

Input FSM, IDLE:
- No request is granted while the tag FIFO is full.
- Otherwise, if exactly one s*_req is high, that requester wins.
- If both are high, the winner is the requester indexed by the priority pointer.
- On a win, latch the owner and go to FEED next cycle.
- The owner's s*_rdy is registered high from the FEED entry cycle; the non-owner's rdy is always 0.

Input FSM, FEED:
- Each owner beat (vld & rdy) is registered to mat_scan: scan_vld_in = 1 and scan_din = sample on the next cycle, i.e. 1-cycle latency.
- Cycles without a beat drive scan_vld_in = 0. Gaps are allowed and are not counted.
- The input counter counts beats 0..BLK-1. On beat BLK-1:
  - push the owner into the tag FIFO;
  - set the priority pointer to the other requester;
  - clear the counter;
  - drop rdy on the next cycle;
  - return to IDLE.
- There is at least one IDLE cycle between blocks.
- s*_req is sampled only in IDLE. Deasserting req during FEED has no effect.

Output routing:
- Each scan_vld_out beat is routed to the FIFO head owner: the matching m*_vld = 1 and m*_dout = scan_dout on the next cycle (1-cycle latency).
- The other m*_vld stays 0. m*_dout holds its last value when m*_vld is 0.
- The output counter counts beats 0..BLK-1. On beat BLK-1, pop the head and clear the counter.
- If scan_vld_out arrives with the FIFO empty: drop the beat, set err_orphan (cleared only by rst), no m*_vld.
- A push (last input beat) and a pop (last output beat) in the same cycle are both performed; occupancy is unchanged.
- A full FIFO blocks new grants only. The block currently in FEED was already accounted for at grant time.
- There is no output backpressure; mat_scan has none.
- busy is registered from the state and FIFO occupancy.

Test Plan:
- Single block: s0_req = 1 with din = 1..64 contiguous -> scan_din 1..64 one cycle after each beat. s0_rdy is high for exactly 64 beats then drops. m0 receives 64 zigzag-ordered values matching result.txt; m1_vld is never high.
- Contention: s0_req and s1_req both high after reset, each with a block -> s0 granted first, then s1. The priority pointer alternates over 4 blocks: order 0,1,0,1.
- Gaps: s0_vld toggles every other cycle -> exactly 64 beats are forwarded with scan_vld_in gaps, and the tag is pushed only on the 64th valid beat.
- Tag full (TAG_DEPTH = 2, scan model delayed 200 cycles): 3 queued blocks -> the third grant is withheld until the first output block completes. Output blocks return to the correct owners in grant order.
- Orphan: scan_vld_out pulsed with the FIFO empty -> err_orphan = 1 and stays high, no m*_vld. rst = 1 for one cycle clears it and all outputs.
- Reset mid-block: rst after 30 beats -> next cycle state is IDLE, rdy = 0, FIFO empty. A new block after reset completes normally with 64 beats.

Source files
------------

// File: rtl/mat_scan_arb.sv
// rtl/mat_scan_arb.sv - block-granular round-robin arbiter sharing one mat_scan engine
// Grants whole 64-beat blocks, feeds mat_scan and routes scanned blocks back by tag.
module mat_scan_arb #(
  parameter int DW        = 10,
  parameter int BLK       = 64,
  parameter int TAG_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s0_req,
  input  logic          s0_vld,
  input  logic [DW-1:0] s0_din,
  output logic          s0_rdy,
  input  logic          s1_req,
  input  logic          s1_vld,
  input  logic [DW-1:0] s1_din,
  output logic          s1_rdy,
  output logic          scan_vld_in,
  output logic [DW-1:0] scan_din,
  input  logic          scan_vld_out,
  input  logic [DW-1:0] scan_dout,
  output logic          m0_vld,
  output logic [DW-1:0] m0_dout,
  output logic          m1_vld,
  output logic [DW-1:0] m1_dout,
  output logic          busy,
  output logic          err_orphan
);

  localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int OW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, FEED} state_t;

  state_t          state_q, state_d;
  logic            owner_q;
  logic            prio_q;
  logic [CW-1:0]   in_cnt_q;
  logic [CW-1:0]   out_cnt_q;
  logic            rdy0_q, rdy1_q;
  logic            scan_vld_q;
  logic [DW-1:0]   scan_din_q;
  logic            m0_vld_q, m1_vld_q;
  logic [DW-1:0]   m0_dout_q, m1_dout_q;
  logic            busy_q, busy_d;
  logic            err_q;
  logic            tag_q [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]   occ_q, occ_d;

  logic            fifo_full, fifo_empty;
  logic            grant, grant_id;
  logic            in_beat, in_last;
  logic [DW-1:0]   in_din;
  logic            out_beat, out_last;
  logic            head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    fifo_full  = (occ_q == OW'(TAG_DEPTH));
    fifo_empty = (occ_q == '0);
    head       = tag_q[rd_ptr_q];

    // A full tag FIFO withholds grants; the block in FEED already owns a slot.
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state_q == IDLE && !fifo_full) begin
      if (s0_req && s1_req) begin
        grant    = 1'b1;
        grant_id = prio_q;
      end else if (s0_req) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (s1_req) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end

    in_beat  = (state_q == FEED) && (owner_q ? (s1_vld && rdy1_q) : (s0_vld && rdy0_q));
    in_din   = owner_q ? s1_din : s0_din;
    in_last  = in_beat && (in_cnt_q == CW'(BLK - 1));

    out_beat = scan_vld_out && !fifo_empty;
    out_last = out_beat && (out_cnt_q == CW'(BLK - 1));

    occ_d    = occ_q + OW'(in_last) - OW'(out_last);

    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)   state_d = FEED;
      FEED:    if (in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FEED) || (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rdy0_q     <= 1'b0;
      rdy1_q     <= 1'b0;
      scan_vld_q <= 1'b0;
      scan_din_q <= '0;
      m0_vld_q   <= 1'b0;
      m1_vld_q   <= 1'b0;
      m0_dout_q  <= '0;
      m1_dout_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      busy_q     <= busy_d;
      scan_vld_q <= in_beat;
      m0_vld_q   <= 1'b0;
      m1_vld_q   <= 1'b0;

      if (grant) begin
        owner_q <= grant_id;
        if (grant_id) rdy1_q <= 1'b1;
        else          rdy0_q <= 1'b1;
      end

      if (in_beat) begin
        scan_din_q <= in_din;
        if (in_last) begin
          in_cnt_q        <= '0;
          prio_q          <= ~owner_q;
          rdy0_q          <= 1'b0;
          rdy1_q          <= 1'b0;
          tag_q[wr_ptr_q] <= owner_q;
          wr_ptr_q        <= ptr_next(wr_ptr_q);
        end else begin
          in_cnt_q <= in_cnt_q + CW'(1);
        end
      end

      // Output beats with no owning tag are dropped and flagged.
      if (scan_vld_out) begin
        if (fifo_empty) begin
          err_q <= 1'b1;
        end else begin
          if (head) begin
            m1_vld_q  <= 1'b1;
            m1_dout_q <= scan_dout;
          end else begin
            m0_vld_q  <= 1'b1;
            m0_dout_q <= scan_dout;
          end
          if (out_last) begin
            out_cnt_q <= '0;
            rd_ptr_q  <= ptr_next(rd_ptr_q);
          end else begin
            out_cnt_q <= out_cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign s0_rdy      = rdy0_q;
  assign s1_rdy      = rdy1_q;
  assign scan_vld_in = scan_vld_q;
  assign scan_din    = scan_din_q;
  assign m0_vld      = m0_vld_q;
  assign m0_dout     = m0_dout_q;
  assign m1_vld      = m1_vld_q;
  assign m1_dout     = m1_dout_q;
  assign busy        = busy_q;
  assign err_orphan  = err_q;

endmodule

// File: tb/tb_mat_scan_arb.sv
// tb/tb_mat_scan_arb.sv - scoreboard bench for mat_scan_arb with a behavioural zigzag engine
module tb_mat_scan_arb;
  localparam int DW  = 10;
  localparam int BLK = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_req = 1'b0, s0_vld = 1'b0, s1_req = 1'b0, s1_vld = 1'b0;
  logic [DW-1:0] s0_din = '0, s1_din = '0;
  logic          s0_rdy, s1_rdy;
  logic          scan_vld_in;
  logic [DW-1:0] scan_din;
  logic          scan_vld_out = 1'b0;
  logic [DW-1:0] scan_dout = '0;
  logic          m0_vld, m1_vld;
  logic [DW-1:0] m0_dout, m1_dout;
  logic          busy, err_orphan;

  always #5 clk = ~clk;

  mat_scan_arb #(.DW(DW), .BLK(BLK), .TAG_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_vld(s0_vld), .s0_din(s0_din), .s0_rdy(s0_rdy),
    .s1_req(s1_req), .s1_vld(s1_vld), .s1_din(s1_din), .s1_rdy(s1_rdy),
    .scan_vld_in(scan_vld_in), .scan_din(scan_din),
    .scan_vld_out(scan_vld_out), .scan_dout(scan_dout),
    .m0_vld(m0_vld), .m0_dout(m0_dout), .m1_vld(m1_vld), .m1_dout(m1_dout),
    .busy(busy), .err_orphan(err_orphan)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // JPEG zigzag: raster index read at each scan position
  int zz [64] = '{ 0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
                  12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
                  35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
                  58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  int exp_scan [$];
  int exp_own  [$];
  int exp_val  [$];
  int grant_log[$];
  int done_log [$];
  int delay      = 0;
  bit orphan_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Behavioural mat_scan: collect 64 beats, emit them zigzag-ordered after 'delay' cycles.
  int m_in[$], m_out[$], m_rdy[$];
  int m_left = 0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        m_in.delete(); m_out.delete(); m_rdy.delete();
        m_left = 0; scan_vld_out = 1'b0; scan_dout = '0;
      end else begin
        scan_vld_out = 1'b0;
        if (m_left == 0 && m_rdy.size() > 0 && cyc >= m_rdy[0]) begin
          void'(m_rdy.pop_front());
          m_left = BLK;
        end
        if (m_left > 0) begin
          scan_vld_out = 1'b1;
          scan_dout    = DW'(m_out.pop_front());
          m_left--;
        end else if (orphan_req) begin
          scan_vld_out = 1'b1;
          scan_dout    = 10'h3a5;
        end
        if (scan_vld_in === 1'b1) begin
          m_in.push_back(int'(scan_din));
          if (m_in.size() == BLK) begin
            for (int k = 0; k < BLK; k++) m_out.push_back(m_in[zz[k]]);
            m_in.delete();
            m_rdy.push_back(cyc + delay);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (scan_vld_in === 1'b1) begin
        if (exp_scan.size() == 0) chk("scan_unexpected", 1, 0);
        else                      chk("scan_din", scan_din, exp_scan.pop_front());
      end
    end
  end

  initial begin
    int own;
    int out_beats;
    bit p0, p1;
    out_beats = 0; p0 = 1'b0; p1 = 1'b0;
    forever begin
      @(negedge clk);
      if (m0_vld === 1'b1 && m1_vld === 1'b1) begin
        chk("m_both_vld", 1, 0);
      end else if (m0_vld === 1'b1 || m1_vld === 1'b1) begin
        own = (m1_vld === 1'b1) ? 1 : 0;
        if (exp_own.size() == 0) begin
          chk("m_unexpected", 1, 0);
        end else begin
          chk("m_owner", own, exp_own.pop_front());
          chk("m_dout", own ? m1_dout : m0_dout, exp_val.pop_front());
        end
        out_beats++;
        if (out_beats % BLK == 0) done_log.push_back(cyc);
      end
      if (s0_rdy === 1'b1 && !p0) grant_log.push_back(0);
      if (s1_rdy === 1'b1 && !p1) grant_log.push_back(1);
      p0 = (s0_rdy === 1'b1);
      p1 = (s1_rdy === 1'b1);
    end
  end

  task automatic set_req(input int r, input logic v);
    if (r == 0) s0_req = v; else s1_req = v;
  endtask

  task automatic set_vld(input int r, input logic v, input int d);
    if (r == 0) begin s0_vld = v; s0_din = DW'(d); end
    else        begin s1_vld = v; s1_din = DW'(d); end
  endtask

  // Drives one block of nb beats (values base+i); a full block also queues its scanned output.
  task automatic feed(input int r, input int base, input bit gaps, input int nb, output int gcyc);
    int   i, guard;
    bit   tog, granted;
    logic rdy, v;
    i = 0; guard = 0; tog = 1'b0; granted = 1'b0; gcyc = 0;
    set_req(r, 1'b1);
    while (i < nb) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        chk("feed_timeout", i, nb);
        break;
      end
      rdy = (r == 0) ? s0_rdy : s1_rdy;
      if (rdy === 1'b1 && !granted) begin
        granted = 1'b1;
        gcyc    = cyc;
        set_req(r, 1'b0);
      end
      v   = gaps ? tog : 1'b1;
      tog = ~tog;
      set_vld(r, v, base + i);
      if (v && rdy === 1'b1) begin
        exp_scan.push_back(base + i);
        i++;
      end
    end
    @(negedge clk);
    set_vld(r, 1'b0, 0);
    set_req(r, 1'b0);
    if (nb == BLK) begin
      chk("rdy_drop", (r == 0) ? s0_rdy : s1_rdy, 0);
      for (int k = 0; k < BLK; k++) begin
        exp_own.push_back(r);
        exp_val.push_back(base + zz[k]);
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((exp_own.size() != 0 || exp_scan.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk("idle_timeout", exp_own.size(), 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_scan.delete(); exp_own.delete(); exp_val.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s0_rdy"},   s0_rdy,      0);
    chk({tag, "_s1_rdy"},   s1_rdy,      0);
    chk({tag, "_scan_vld"}, scan_vld_in, 0);
    chk({tag, "_scan_din"}, scan_din,    0);
    chk({tag, "_m0_vld"},   m0_vld,      0);
    chk({tag, "_m0_dout"},  m0_dout,     0);
    chk({tag, "_m1_vld"},   m1_vld,      0);
    chk({tag, "_m1_dout"},  m1_dout,     0);
    chk({tag, "_busy"},     busy,        0);
    chk({tag, "_err"},      err_orphan,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int g, g0, g1, gc, n0, nd;
    int ord4 [4] = '{0, 1, 0, 1};
    int ord3 [3] = '{0, 1, 0};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // single block, din 1..64
    feed(0, 1, 1'b0, BLK, g);
    wait_idle(500);

    // contention: both request, 4 blocks alternate 0,1,0,1
    do_reset();
    n0 = grant_log.size();
    fork
      begin feed(0, 100, 1'b0, BLK, g0); feed(0, 300, 1'b0, BLK, g0); end
      begin feed(1, 200, 1'b0, BLK, g1); feed(1, 400, 1'b0, BLK, g1); end
    join
    wait_idle(1000);
    chk("contention_grants", grant_log.size() - n0, 4);
    for (int k = 0; k < 4; k++)
      if (grant_log.size() > n0 + k) chk("contention_order", grant_log[n0 + k], ord4[k]);

    // gapped valid
    do_reset();
    feed(0, 500, 1'b1, BLK, g);
    wait_idle(500);

    // tag FIFO full with a slow engine
    do_reset();
    delay = 200;
    n0 = grant_log.size();
    nd = done_log.size();
    fork
      begin feed(0, 600, 1'b0, BLK, g0); feed(0, 700, 1'b0, BLK, gc); end
      begin feed(1, 650, 1'b0, BLK, g1); end
    join
    chk("tagfull_busy", busy, 1);
    wait_idle(3000);
    delay = 0;
    chk("tagfull_grants", grant_log.size() - n0, 3);
    for (int k = 0; k < 3; k++)
      if (grant_log.size() > n0 + k) chk("tagfull_order", grant_log[n0 + k], ord3[k]);
    chk("tagfull_blocks", done_log.size() - nd, 3);
    if (done_log.size() > nd) chk("third_grant_delay", gc - done_log[nd], 1);

    // orphan output beat
    do_reset();
    @(negedge clk); orphan_req = 1'b1;
    @(negedge clk); orphan_req = 1'b0;
    chk("orphan_err", err_orphan, 1);
    chk("orphan_m0_vld", m0_vld, 0);
    chk("orphan_m1_vld", m1_vld, 0);
    repeat (5) @(negedge clk);
    chk("orphan_sticky", err_orphan, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_zero("orphan_rst");

    // reset mid-block, then a clean block
    do_reset();
    feed(0, 800, 1'b0, 30, g);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_rdy", s0_rdy, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_scan_vld", scan_vld_in, 0);
    exp_scan.delete(); exp_own.delete(); exp_val.delete();
    feed(0, 900, 1'b0, BLK, g);
    wait_idle(500);
    chk("final_err", err_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
